// File: rtl/spi_tx_div4_pkg.sv
// Shared definitions for the clk_4-paced SPI mode-0 transmitter: FSM state
// encodings and the SPI bus levels used while the bus is idle.
package spi_tx_div4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_e;

   // SPI mode 0: clock idles low, data is sampled on the rising edge
   localparam logic SPI_CPOL    = 1'b0;
   localparam logic SPI_CPHA    = 1'b0;
   localparam logic SCLK_IDLE   = SPI_CPOL;
   localparam logic CS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_tx_div4_edge_det.sv
// Edge detector for a slow clock that is carried as data in the clk domain.
// Any clk_4 consumer can reuse it to get single-cycle rise/fall strobes.
module edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_d_q;

   // Remember last cycle's level so an edge shows up as a one-cycle strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_d_q <= 1'b0;
      end else begin
         sig_d_q <= sig;
      end
   end

   assign rise = sig & ~sig_d_q;
   assign fall = ~sig & sig_d_q;

endmodule

// File: rtl/spi_tx_div4.sv
// Mode-0 SPI master transmitter paced by the divide-by-4 clock stage.
// Every state advance happens on a clk_4 fall; sclk is clk_4 delayed by one
// clk while shifting, so mosi always changes on the same edge that sclk falls.
module spi_tx_div4
   import spi_tx_div4_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1,
   parameter int CS_HOLD   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_4,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              done
);

   localparam int BW = $clog2(DATA_W);
   localparam int HW = $clog2(CS_HOLD + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic              tx_ready_q, tx_ready_d;
   logic              done_q, done_d;
   logic              rise, fall;

   edge_det u_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (clk_4),
      .rise  (rise),
      .fall  (fall)
   );

   // Next-state logic for the transfer FSM, shift register and counters
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      hold_cnt_d = hold_cnt_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      tx_ready_d = tx_ready_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sclk_d     = SCLK_IDLE;
            cs_n_d     = CS_INACTIVE;
            tx_ready_d = 1'b1;
            if (tx_valid && tx_ready_q) begin
               shreg_d    = tx_data;
               mosi_d     = (MSB_FIRST != 0) ? tx_data[DATA_W-1] : tx_data[0];
               cs_n_d     = ~CS_INACTIVE;
               tx_ready_d = 1'b0;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            sclk_d = SCLK_IDLE;
            if (fall) begin
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sclk_d = clk_4;
            if (fall) begin
               if (bit_cnt_q == LAST_BIT) begin
                  sclk_d     = SCLK_IDLE;
                  hold_cnt_d = '0;
                  state_d    = ST_HOLD;
               end else begin
                  if (MSB_FIRST != 0) begin
                     shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                     mosi_d  = shreg_q[DATA_W-2];
                  end else begin
                     shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                     mosi_d  = shreg_q[1];
                  end
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            sclk_d     = SCLK_IDLE;
            cs_n_d     = ~CS_INACTIVE;
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LAST) begin
               cs_n_d     = CS_INACTIVE;
               done_d     = 1'b1;
               tx_ready_d = 1'b1;
               hold_cnt_d = '0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transfer immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         sclk_q     <= SCLK_IDLE;
         mosi_q     <= 1'b0;
         cs_n_q     <= CS_INACTIVE;
         tx_ready_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         tx_ready_q <= tx_ready_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
   assign done     = done_q;

   // While shifting, a clk_4 rise must show up on sclk exactly one clk later
   sclk_follows_rise: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == ST_SHIFT && rise) |=> sclk_q
   );

endmodule

// File: tb/tb_spi_tx_div4.sv
// Directed bench for spi_tx_div4: one MSB-first and one LSB-first instance
// share the stimulus; an upstream divide-by-4 model (which can be frozen low)
// supplies clk_4.
module tb_spi_tx_div4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       clk4_stop = 1'b0;
   logic [1:0] div_q = 2'd0;
   logic       clk_4;

   logic m_tx_ready, m_sclk, m_mosi, m_cs_n, m_done;
   logic l_tx_ready, l_sclk, l_mosi, l_cs_n, l_done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Upstream divider model: 2 high / 2 low, forced low while "in reset"
   always @(posedge clk) begin
      if (clk4_stop) div_q <= 2'd0;
      else           div_q <= div_q + 2'd1;
   end
   assign clk_4 = div_q[1];

   spi_tx_div4 #(.DATA_W(8), .MSB_FIRST(1), .CS_HOLD(2)) dut_msb (
      .clk(clk), .rst_n(rst_n), .clk_4(clk_4), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(m_tx_ready), .sclk(m_sclk), .mosi(m_mosi), .cs_n(m_cs_n), .done(m_done)
   );

   spi_tx_div4 #(.DATA_W(8), .MSB_FIRST(0), .CS_HOLD(2)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .clk_4(clk_4), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(l_tx_ready), .sclk(l_sclk), .mosi(l_mosi), .cs_n(l_cs_n), .done(l_done)
   );

   // Present one request for a single cycle; it is accepted at the posedge in between
   task automatic send(input logic [7:0] data);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = data;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Watch one instance until done (or budget), recording mosi at each sclk rise
   task automatic capture(input bit use_lsb, input int budget,
                          output logic [7:0] bits, output int rises, output int done_cnt,
                          output int gap, output int hi_min, output int hi_max,
                          output int lo_min, output int lo_max, output int ready_hi,
                          output int cs_hi, output bit timed_out);
      logic s, m, c, d, r, prev;
      int run, last_fall;
      bits = 8'h00; rises = 0; done_cnt = 0; gap = -1;
      hi_min = 99; hi_max = 0; lo_min = 99; lo_max = 0;
      ready_hi = 0; cs_hi = 0; timed_out = 1'b1;
      prev = 1'b0; run = 0; last_fall = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         s = use_lsb ? l_sclk     : m_sclk;
         m = use_lsb ? l_mosi     : m_mosi;
         c = use_lsb ? l_cs_n     : m_cs_n;
         d = use_lsb ? l_done     : m_done;
         r = use_lsb ? l_tx_ready : m_tx_ready;
         if (s && !prev) begin
            bits = {bits[6:0], m};
            if (rises > 0) begin
               if (run < lo_min) lo_min = run;
               if (run > lo_max) lo_max = run;
            end
            rises++;
            run = 1;
         end else if (!s && prev) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
            last_fall = cyc;
            run = 1;
         end else begin
            run++;
         end
         prev = s;
         if (d) begin
            done_cnt++;
            gap = cyc - last_fall;
            timed_out = 1'b0;
            break;
         end
         if (r) ready_hi++;
         if (c) cs_hi++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (m_tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_ready got=%b want=1", m_tx_ready); end
      total++; if (m_cs_n !== 1'b1)     begin bad++; $display("[TB] FAIL reset_cs_n got=%b want=1", m_cs_n); end
      total++; if (m_sclk !== 1'b0)     begin bad++; $display("[TB] FAIL reset_sclk got=%b want=0", m_sclk); end
      total++; if (m_mosi !== 1'b0)     begin bad++; $display("[TB] FAIL reset_mosi got=%b want=0", m_mosi); end
      total++; if (m_done !== 1'b0)     begin bad++; $display("[TB] FAIL reset_done got=%b want=0", m_done); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++; if ({m_tx_ready, m_cs_n, m_sclk, m_mosi, m_done} !== 5'b11000)
         begin bad++; $display("[TB] FAIL idle_after_release got=%b want=11000", {m_tx_ready, m_cs_n, m_sclk, m_mosi, m_done}); end
      total++; if ({l_tx_ready, l_cs_n, l_sclk, l_mosi, l_done} !== 5'b11000)
         begin bad++; $display("[TB] FAIL idle_after_release_lsb got=%b want=11000", {l_tx_ready, l_cs_n, l_sclk, l_mosi, l_done}); end
   endtask

   task automatic test_msb_first();
      logic [7:0] bits; int rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch; bit to;
      send(8'hA5);
      capture(1'b0, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (to !== 1'b0)   begin bad++; $display("[TB] FAIL msb_timeout got=%b want=0", to); end
      total++; if (bits !== 8'hA5) begin bad++; $display("[TB] FAIL msb_bits got=%h want=a5", bits); end
      total++; if (rises !== 8)   begin bad++; $display("[TB] FAIL msb_rises got=%0d want=8", rises); end
      total++; if (ch !== 0)      begin bad++; $display("[TB] FAIL msb_cs_high_cycles got=%0d want=0", ch); end
      total++; if (gap !== 2)     begin bad++; $display("[TB] FAIL msb_done_gap got=%0d want=2", gap); end
      total++; if (rh !== 0)      begin bad++; $display("[TB] FAIL msb_ready_during got=%0d want=0", rh); end
      @(negedge clk);
      total++; if ({m_done, m_cs_n, m_tx_ready} !== 3'b011)
         begin bad++; $display("[TB] FAIL msb_after_done got=%b want=011", {m_done, m_cs_n, m_tx_ready}); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] bits; int rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch; bit to;
      send(8'h01);
      capture(1'b1, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (to !== 1'b0)    begin bad++; $display("[TB] FAIL lsb_timeout got=%b want=0", to); end
      total++; if (bits !== 8'h80) begin bad++; $display("[TB] FAIL lsb_bits got=%h want=80", bits); end
      total++; if (rises !== 8)    begin bad++; $display("[TB] FAIL lsb_rises got=%0d want=8", rises); end
      total++; if (hmin !== 2 || hmax !== 2)
         begin bad++; $display("[TB] FAIL lsb_sclk_high got=%0d..%0d want=2..2", hmin, hmax); end
      total++; if (lmin !== 2 || lmax !== 2)
         begin bad++; $display("[TB] FAIL lsb_sclk_low got=%0d..%0d want=2..2", lmin, lmax); end
      total++; if (dn !== 1)       begin bad++; $display("[TB] FAIL lsb_done_count got=%0d want=1", dn); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bits; int rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch; bit to;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      @(negedge clk);
      tx_data  = 8'hFF;
      capture(1'b0, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (bits !== 8'h3C || to !== 1'b0)
         begin bad++; $display("[TB] FAIL b2b_first_bits got=%h timeout=%b want=3c", bits, to); end
      total++; if (rh !== 0) begin bad++; $display("[TB] FAIL b2b_ready_during got=%0d want=0", rh); end
      total++; if ({m_cs_n, m_tx_ready} !== 2'b11)
         begin bad++; $display("[TB] FAIL b2b_gap_state got=%b want=11", {m_cs_n, m_tx_ready}); end
      @(negedge clk);
      tx_valid = 1'b0;
      total++; if ({m_cs_n, m_tx_ready} !== 2'b00)
         begin bad++; $display("[TB] FAIL b2b_second_accept got=%b want=00", {m_cs_n, m_tx_ready}); end
      capture(1'b0, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (bits !== 8'hFF || to !== 1'b0)
         begin bad++; $display("[TB] FAIL b2b_second_bits got=%h timeout=%b want=ff", bits, to); end
      total++; if (rises !== 8) begin bad++; $display("[TB] FAIL b2b_second_rises got=%0d want=8", rises); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] bits; int rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch; bit to;
      int seen, dones;
      logic prev;
      send(8'hC3);
      seen = 0; prev = 1'b0;
      for (int i = 0; i < 100 && seen < 3; i++) begin
         @(negedge clk);
         if (m_sclk && !prev) seen++;
         prev = m_sclk;
      end
      total++; if (seen !== 3) begin bad++; $display("[TB] FAIL abort_third_rise got=%0d want=3", seen); end
      rst_n = 1'b0;
      #1;
      total++; if ({m_cs_n, m_sclk, m_tx_ready, m_done} !== 4'b1010)
         begin bad++; $display("[TB] FAIL abort_immediate got=%b want=1010", {m_cs_n, m_sclk, m_tx_ready, m_done}); end
      dones = 0;
      repeat (3) begin @(negedge clk); if (m_done) dones++; end
      rst_n = 1'b1;
      repeat (40) begin @(negedge clk); if (m_done) dones++; end
      total++; if (dones !== 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", dones); end
      send(8'h55);
      capture(1'b0, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (bits !== 8'h55 || to !== 1'b0 || rises !== 8)
         begin bad++; $display("[TB] FAIL abort_resend got=%h rises=%0d timeout=%b want=55 rises=8", bits, rises, to); end
   endtask

   task automatic test_clk4_stuck();
      logic [7:0] bits; int rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch; bit to;
      int bad_cyc;
      @(negedge clk);
      clk4_stop = 1'b1;
      repeat (3) @(negedge clk);
      send(8'h81);
      bad_cyc = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_cs_n !== 1'b0 || m_sclk !== 1'b0 || m_tx_ready !== 1'b0 || m_done !== 1'b0) bad_cyc++;
      end
      total++; if (bad_cyc !== 0) begin bad++; $display("[TB] FAIL stuck_wait got=%0d bad cycles want=0", bad_cyc); end
      clk4_stop = 1'b0;
      capture(1'b0, 100, bits, rises, dn, gap, hmin, hmax, lmin, lmax, rh, ch, to);
      total++; if (bits !== 8'h81 || to !== 1'b0)
         begin bad++; $display("[TB] FAIL stuck_resume_bits got=%h timeout=%b want=81", bits, to); end
      total++; if (rises !== 8) begin bad++; $display("[TB] FAIL stuck_resume_rises got=%0d want=8", rises); end
   endtask

   initial begin
      $display("[TB] starting spi_tx_div4 directed tests");
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_reset_abort();
      test_clk4_stuck();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
